// File: rtl/bus68k_pkg.sv
// rtl/bus68k_pkg.sv - shared types and constants for the 68000 bus decoder
package bus68k_pkg;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_PROM,
        RGN_SRAM,
        RGN_IO,
        RGN_IACK
    } region_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_ERR_WAIT,
        ST_BERR
    } state_e;

    localparam logic [3:0] REGION_SRAM = 4'h0;
    localparam logic [3:0] REGION_PROM = 4'hF;
    localparam int         WAIT_W      = 8;

endpackage

// File: rtl/bus_watchdog.sv
// rtl/bus_watchdog.sv - bus-cycle watchdog counting falling edges while AS is high
module bus_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_as,
    output logic o_expired
);

    localparam int              CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0]   LAST  = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_as) begin
            r_cnt <= '0;
        end else if (r_cnt != LIMIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // High on the edge where the count reaches TIMEOUT, so BERR lands exactly on it.
    assign o_expired = i_as && (r_cnt >= LAST);

endmodule

// File: rtl/bus_decoder_68k.sv
// rtl/bus_decoder_68k.sv - 68000 select/strobe/handshake controller with waits, watchdog and IACK
module bus_decoder_68k
    import bus68k_pkg::*;
#(
    parameter int          NUM_IO    = 4,
    parameter logic [23:0] IO_BASE   = 24'h100000,
    parameter int          PROM_WAIT = 2,
    parameter int          SRAM_WAIT = 0,
    parameter int          IO_WAIT   = 1,
    parameter int          TIMEOUT   = 64
) (
    input  logic              MCLK_IN,
    input  logic              RUN_IN,
    input  logic              AS_IN,
    input  logic              WR_IN,
    input  logic              UDS_IN,
    input  logic              LDS_IN,
    input  logic [2:0]        FC_IN,
    input  logic [23:0]       ADDR_IN,
    input  logic              ACK_GATE_IN,
    output logic [1:0]        PROM_CS,
    output logic [1:0]        SRAM_CS,
    output logic              OUTPUT_ENABLE,
    output logic [NUM_IO-1:0] IO_SEL,
    output logic              IO_RD,
    output logic              IO_WR,
    output logic              IACK,
    output logic [2:0]        IACK_LEVEL,
    output logic              DATA_ACK,
    output logic              BUS_ERROR,
    output logic              BOOTSTRAPPED
);

    state_e              r_state, w_next;
    region_e             w_region;
    logic                w_expired, w_strobe, w_io_hit, w_io_ok;
    logic                w_decode, w_release, w_unused_a0;
    logic [WAIT_W-1:0]   w_wait_load, r_wait_cnt;
    logic [NUM_IO-1:0]   w_io_onehot, r_io_sel;
    logic [1:0]          r_prom_cs, r_sram_cs;
    logic [2:0]          r_iack_level;
    logic                r_oe, r_io_rd, r_io_wr, r_iack, r_boot;

    assign w_unused_a0 = ADDR_IN[0];
    assign w_strobe    = AS_IN && (UDS_IN || LDS_IN);

    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .i_clk     (MCLK_IN),
        .i_rst_n   (RUN_IN),
        .i_as      (AS_IN),
        .o_expired (w_expired)
    );

    always_comb begin
        w_io_hit    = (ADDR_IN[23:20] == IO_BASE[23:20]) && (ADDR_IN[19:5] == IO_BASE[19:5]);
        w_io_ok     = LDS_IN && !UDS_IN && ({1'b0, ADDR_IN[4:1]} < 5'(NUM_IO));
        w_io_onehot = NUM_IO'(1) << ADDR_IN[4:1];
        w_region    = RGN_NONE;
        if (FC_IN == 3'b111) begin
            w_region = (UDS_IN && LDS_IN) ? RGN_IACK : RGN_NONE;
        end else if (w_io_hit) begin
            w_region = w_io_ok ? RGN_IO : RGN_NONE;
        end else if (ADDR_IN[23:20] == REGION_SRAM) begin
            // Boot overlay: low-memory reads hit PROM until the first low-memory write.
            w_region = (!WR_IN && !r_boot) ? RGN_PROM : RGN_SRAM;
        end else if (ADDR_IN[23:20] == REGION_PROM) begin
            w_region = RGN_PROM;
        end
        case (w_region)
            RGN_PROM: w_wait_load = WAIT_W'(PROM_WAIT);
            RGN_SRAM: w_wait_load = WAIT_W'(SRAM_WAIT);
            RGN_IO:   w_wait_load = WAIT_W'(IO_WAIT);
            default:  w_wait_load = '0;
        endcase
    end

    always_ff @(negedge MCLK_IN or negedge RUN_IN) begin
        if (!RUN_IN) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_expired)     w_next = ST_BERR;
                else if (w_strobe) w_next = (w_region == RGN_NONE) ? ST_ERR_WAIT : ST_WAIT;
            end
            ST_WAIT: begin
                if (!AS_IN)                                    w_next = ST_IDLE;
                else if (w_expired)                            w_next = ST_BERR;
                else if ((r_wait_cnt == '0) && ACK_GATE_IN)    w_next = ST_ACK;
            end
            ST_ACK:      if (!AS_IN) w_next = ST_IDLE;
            ST_ERR_WAIT: begin
                if (!AS_IN)         w_next = ST_IDLE;
                else if (w_expired) w_next = ST_BERR;
            end
            ST_BERR:     if (!AS_IN) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        DATA_ACK  = (r_state == ST_ACK);
        BUS_ERROR = (r_state == ST_BERR);
    end

    assign w_decode  = (r_state == ST_IDLE) && (w_next == ST_WAIT);
    assign w_release = (w_next == ST_IDLE) || (w_next == ST_BERR);

    always_ff @(negedge MCLK_IN or negedge RUN_IN) begin
        if (!RUN_IN) begin
            r_wait_cnt   <= '0;
            r_prom_cs    <= '0;
            r_sram_cs    <= '0;
            r_oe         <= 1'b0;
            r_io_sel     <= '0;
            r_io_rd      <= 1'b0;
            r_io_wr      <= 1'b0;
            r_iack       <= 1'b0;
            r_iack_level <= '0;
            r_boot       <= 1'b0;
        end else begin
            r_io_wr <= 1'b0;
            if (w_decode) begin
                r_wait_cnt   <= w_wait_load;
                r_prom_cs    <= (w_region == RGN_PROM) ? {UDS_IN, LDS_IN} : 2'b00;
                r_sram_cs    <= (w_region == RGN_SRAM) ? {UDS_IN, LDS_IN} : 2'b00;
                r_oe         <= !WR_IN && ((w_region == RGN_PROM) || (w_region == RGN_SRAM));
                r_io_sel     <= (w_region == RGN_IO) ? w_io_onehot : '0;
                r_io_rd      <= !WR_IN && (w_region == RGN_IO);
                r_io_wr      <= WR_IN && (w_region == RGN_IO);
                r_iack       <= (w_region == RGN_IACK);
                r_iack_level <= (w_region == RGN_IACK) ? ADDR_IN[3:1] : 3'd0;
                if ((w_region == RGN_SRAM) && WR_IN && (ADDR_IN[23:20] == REGION_SRAM))
                    r_boot <= 1'b1;
            end else if (w_release) begin
                r_wait_cnt   <= '0;
                r_prom_cs    <= '0;
                r_sram_cs    <= '0;
                r_oe         <= 1'b0;
                r_io_sel     <= '0;
                r_io_rd      <= 1'b0;
                r_iack       <= 1'b0;
                r_iack_level <= '0;
            end else if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end
        end
    end

    assign PROM_CS       = r_prom_cs;
    assign SRAM_CS       = r_sram_cs;
    assign OUTPUT_ENABLE = r_oe;
    assign IO_SEL        = r_io_sel;
    assign IO_RD         = r_io_rd;
    assign IO_WR         = r_io_wr;
    assign IACK          = r_iack;
    assign IACK_LEVEL    = r_iack_level;
    assign BOOTSTRAPPED  = r_boot;

endmodule

// File: tb/tb_bus_decoder_68k.sv
// tb/tb_bus_decoder_68k.sv - directed table-driven bench for bus_decoder_68k
module tb_bus_decoder_68k;

    logic        MCLK_IN, RUN_IN, AS_IN, WR_IN, UDS_IN, LDS_IN, ACK_GATE_IN;
    logic [2:0]  FC_IN;
    logic [23:0] ADDR_IN;
    logic [1:0]  PROM_CS, SRAM_CS;
    logic        OUTPUT_ENABLE, IO_RD, IO_WR, IACK, DATA_ACK, BUS_ERROR, BOOTSTRAPPED;
    logic [3:0]  IO_SEL;
    logic [2:0]  IACK_LEVEL;

    int n_pass  = 0;
    int n_total = 0;

    bus_decoder_68k dut (
        .MCLK_IN(MCLK_IN), .RUN_IN(RUN_IN), .AS_IN(AS_IN), .WR_IN(WR_IN),
        .UDS_IN(UDS_IN), .LDS_IN(LDS_IN), .FC_IN(FC_IN), .ADDR_IN(ADDR_IN),
        .ACK_GATE_IN(ACK_GATE_IN), .PROM_CS(PROM_CS), .SRAM_CS(SRAM_CS),
        .OUTPUT_ENABLE(OUTPUT_ENABLE), .IO_SEL(IO_SEL), .IO_RD(IO_RD), .IO_WR(IO_WR),
        .IACK(IACK), .IACK_LEVEL(IACK_LEVEL), .DATA_ACK(DATA_ACK),
        .BUS_ERROR(BUS_ERROR), .BOOTSTRAPPED(BOOTSTRAPPED)
    );

    initial begin
        MCLK_IN = 1'b1;
        forever #5 MCLK_IN = ~MCLK_IN;
    end

    typedef struct {
        logic [23:0] addr;
        logic        wr, uds, lds;
        logic [2:0]  fc;
        logic [1:0]  prom, sram;
        logic        oe;
        logic [3:0]  sel;
        logic        rd, iack;
        logic [2:0]  lvl;
        int          lat;
        logic        berr, boot;
        int          pulses;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(negedge MCLK_IN);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic logic [16:0] all_outs();
        return {PROM_CS, SRAM_CS, OUTPUT_ENABLE, IO_SEL, IO_RD, IO_WR, IACK, IACK_LEVEL, DATA_ACK, BUS_ERROR};
    endfunction

    function automatic logic [13:0] sel_snap();
        return {PROM_CS, SRAM_CS, OUTPUT_ENABLE, IO_SEL, IO_RD, IACK, IACK_LEVEL};
    endfunction

    task automatic start(input logic [23:0] a, input logic w, input logic u, input logic l, input logic [2:0] f);
        ADDR_IN = a; WR_IN = w; UDS_IN = u; LDS_IN = l; FC_IN = f; AS_IN = 1'b1;
    endtask

    task automatic end_cycle();
        AS_IN = 1'b0; UDS_IN = 1'b0; LDS_IN = 1'b0; WR_IN = 1'b0;
        tick();
    endtask

    initial begin
        vec_t v;
        logic [13:0] exp_snap;
        int n, pulses;
        logic seen;

        //          addr      wr    uds   lds   fc    prom   sram   oe   sel      rd   iack lvl  lat berr boot pulses
        vecs[0]  = '{24'h000000, 1'b0, 1'b1, 1'b1, 3'd5, 2'b11, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 3,  1'b0, 1'b0, 0};
        vecs[1]  = '{24'h000100, 1'b1, 1'b1, 1'b1, 3'd5, 2'b00, 2'b11, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 1,  1'b0, 1'b1, 0};
        vecs[2]  = '{24'h000100, 1'b0, 1'b1, 1'b1, 3'd5, 2'b00, 2'b11, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 1,  1'b0, 1'b1, 0};
        vecs[3]  = '{24'hF00010, 1'b0, 1'b0, 1'b1, 3'd6, 2'b01, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 3,  1'b0, 1'b1, 0};
        vecs[4]  = '{24'hF00000, 1'b0, 1'b1, 1'b0, 3'd6, 2'b10, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 3,  1'b0, 1'b1, 0};
        vecs[5]  = '{24'h100005, 1'b1, 1'b0, 1'b1, 3'd5, 2'b00, 2'b00, 1'b0, 4'b0100, 1'b0, 1'b0, 3'd0, 2,  1'b0, 1'b1, 1};
        vecs[6]  = '{24'h100001, 1'b0, 1'b0, 1'b1, 3'd5, 2'b00, 2'b00, 1'b0, 4'b0001, 1'b1, 1'b0, 3'd0, 2,  1'b0, 1'b1, 0};
        vecs[7]  = '{24'h100009, 1'b1, 1'b0, 1'b1, 3'd5, 2'b00, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 63, 1'b1, 1'b1, 0};
        vecs[8]  = '{24'h500000, 1'b0, 1'b1, 1'b1, 3'd5, 2'b00, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 63, 1'b1, 1'b1, 0};
        vecs[9]  = '{24'h00000A, 1'b0, 1'b1, 1'b1, 3'd7, 2'b00, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd5, 1,  1'b0, 1'b1, 0};
        vecs[10] = '{24'h100007, 1'b1, 1'b1, 1'b1, 3'd5, 2'b00, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 63, 1'b1, 1'b1, 0};

        RUN_IN = 1'b0; AS_IN = 1'b0; WR_IN = 1'b0; UDS_IN = 1'b0; LDS_IN = 1'b0;
        FC_IN = 3'd0; ADDR_IN = '0; ACK_GATE_IN = 1'b1;
        tick(); tick();
        chk("reset outs", 32'(all_outs()), 32'd0);
        chk("reset boot", 32'(BOOTSTRAPPED), 32'd0);
        RUN_IN = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            exp_snap = {v.prom, v.sram, v.oe, v.sel, v.rd, v.iack, v.lvl};
            start(v.addr, v.wr, v.uds, v.lds, v.fc);
            tick();
            chk($sformatf("v%0d selects", i), 32'(sel_snap()), 32'(exp_snap));
            pulses = int'(IO_WR);
            n = 0;
            while (!DATA_ACK && !BUS_ERROR && n < 200) begin
                tick();
                n++;
                pulses += int'(IO_WR);
            end
            chk($sformatf("v%0d latency", i), 32'(n), 32'(v.lat));
            chk($sformatf("v%0d ack/berr", i), {30'd0, DATA_ACK, BUS_ERROR}, v.berr ? 32'd1 : 32'd2);
            chk($sformatf("v%0d held sel", i), 32'(sel_snap()), v.berr ? 32'd0 : 32'(exp_snap));
            chk($sformatf("v%0d io_wr pulses", i), 32'(pulses), 32'(v.pulses));
            chk($sformatf("v%0d boot", i), 32'(BOOTSTRAPPED), 32'(v.boot));
            end_cycle();
            chk($sformatf("v%0d release", i), 32'(all_outs()), 32'd0);
        end

        // Gate held low, released after edge 10: acknowledge on the next edge.
        ACK_GATE_IN = 1'b0;
        start(24'h000100, 1'b0, 1'b1, 1'b1, 3'd5);
        tick();
        chk("gate sram_cs", 32'(SRAM_CS), 32'd3);
        for (int k = 0; k < 9; k++) tick();
        chk("gate ack low", 32'(DATA_ACK), 32'd0);
        ACK_GATE_IN = 1'b1;
        tick();
        chk("gate ack rise", 32'(DATA_ACK), 32'd1);
        end_cycle();
        chk("gate release", 32'(all_outs()), 32'd0);

        // Gate never released: watchdog fires on edge 64 after AS.
        ACK_GATE_IN = 1'b0;
        start(24'h000100, 1'b0, 1'b1, 1'b1, 3'd5);
        tick();
        n = 1;
        while (!BUS_ERROR && n < 200) begin
            tick();
            n++;
        end
        chk("stuck gate berr edge", 32'(n), 32'd64);
        chk("stuck gate outs", 32'(all_outs()), 32'd1);
        ACK_GATE_IN = 1'b1;
        end_cycle();
        chk("stuck gate release", 32'(all_outs()), 32'd0);

        // Aborted cycle mid-WAIT: no ack and no berr afterwards.
        start(24'hF00000, 1'b0, 1'b1, 1'b1, 3'd6);
        tick(); tick();
        end_cycle();
        chk("abort outs", 32'(all_outs()), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            seen = seen | DATA_ACK | BUS_ERROR;
        end
        chk("abort no handshake", 32'(seen), 32'd0);

        // Asynchronous reset mid-WAIT.
        start(24'hF00000, 1'b0, 1'b1, 1'b1, 3'd6);
        tick();
        chk("pre-reset prom_cs", 32'(PROM_CS), 32'd3);
        RUN_IN = 1'b0;
        #1;
        chk("async reset outs", 32'(all_outs()), 32'd0);
        chk("async reset boot", 32'(BOOTSTRAPPED), 32'd0);
        AS_IN = 1'b0; UDS_IN = 1'b0; LDS_IN = 1'b0;
        RUN_IN = 1'b1;
        tick();
        chk("post-reset outs", 32'(all_outs()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
